// File: rtl/sata_identify_pkg.sv
// Constants and types shared by the IDENTIFY generator and the matching parser.
// Holds the frame length, the beat indices of the populated identify words,
// the 28-bit LBA ceiling, the word-255 signature and the FSM state type.
`include "sata_defs.svh"

package sata_identify_pkg;

   localparam logic [7:0]  DATA_FIS      = `SATA_DATA_FIS;

   // One header dword plus 256 identify words packed two per dword.
   localparam int unsigned FIS_LEN       = 129;

   // Beat index n carries identify words 2(n-1) and 2(n-1)+1.
   localparam logic [7:0]  BEAT_HEADER   = 8'd0;
   localparam logic [7:0]  BEAT_LBA28    = 8'd31;   // words 60/61
   localparam logic [7:0]  BEAT_SATA_CAP = 8'd39;   // word 76
   localparam logic [7:0]  BEAT_CMD_SET  = 8'd42;   // word 83
   localparam logic [7:0]  BEAT_LBA48_LO = 8'd51;   // words 100/101
   localparam logic [7:0]  BEAT_LBA48_HI = 8'd52;   // words 102/103
   localparam logic [7:0]  BEAT_LAST     = 8'(FIS_LEN - 1);  // words 254/255

   localparam logic [27:0] LBA28_MAX     = 28'h0FFF_FFFF;
   localparam logic [7:0]  ID_SIGNATURE  = 8'hA5;
   // 48-bit address feature set supported, bit 14 marks the word valid.
   localparam logic [15:0] WORD83_VAL    = 16'h4400;

   typedef enum logic [0:0] {
      StIdle,
      StSend
   } gen_state_e;

   // Mod-256 sum of the four bytes of a dword.
   function automatic logic [7:0] dword_byte_sum(input logic [31:0] d);
      return d[7:0] + d[15:8] + d[23:16] + d[31:24];
   endfunction

endpackage

// File: rtl/sata_defs.svh
// Shared SATA protocol definitions.
// Provides the FIS type codes used by the IDENTIFY generator and parser.
`ifndef SATA_DEFS_SVH
`define SATA_DEFS_SVH

// Data FIS type code: first byte of every data frame.
`define SATA_DATA_FIS 8'h46

`endif

// File: rtl/sata_identify_dword_mux.sv
// Combinational IDENTIFY dword builder.
// Maps a beat index plus the latched capability/LBA fields and the running
// byte accumulator onto the 32-bit frame dword for that beat.
// Ports:
//   beat_i  beat index 0..128
//   caps_i  {sata3, sata2, sata1} capability flags
//   lba_i   48-bit maximum user LBA
//   acc_i   mod-256 byte sum of beats 1..127 already sent
//   dat_o   frame dword for beat_i
module sata_identify_dword_mux
   import sata_identify_pkg::*;
(
   input  logic [7:0]  beat_i,
   input  logic [2:0]  caps_i,
   input  logic [47:0] lba_i,
   input  logic [7:0]  acc_i,
   output logic [31:0] dat_o
);

   logic [27:0] lba28;
   logic [7:0]  checksum;

   always_comb begin
      // Drives larger than 28 bits report the 28-bit ceiling.
      lba28 = (lba_i < {20'd0, LBA28_MAX}) ? lba_i[27:0] : LBA28_MAX;
      // Byte 511 makes the 512-byte sum zero; byte 510 is the signature.
      checksum = 8'h00 - acc_i - ID_SIGNATURE;

      dat_o = '0;
      case (beat_i)
         BEAT_HEADER:   dat_o = {24'd0, DATA_FIS};
         BEAT_LBA28:    dat_o = {4'd0, lba28};
         BEAT_SATA_CAP: dat_o = {28'd0, caps_i, 1'b0};
         BEAT_CMD_SET:  dat_o = {WORD83_VAL, 16'd0};
         BEAT_LBA48_LO: dat_o = lba_i[31:0];
         BEAT_LBA48_HI: dat_o = {16'd0, lba_i[47:32]};
         BEAT_LAST:     dat_o = {checksum, ID_SIGNATURE, 16'd0};
         default:       dat_o = '0;
      endcase
   end

endmodule

// File: rtl/sata_identify_generator.sv
// SATA IDENTIFY DEVICE data frame generator.
// On start (while idle) latches the capability flags and max LBA, then
// streams a 129-dword frame (data FIS header + 256 identify words) over a
// valid/ready interface, appending a checksum so the 512 identify bytes sum
// to zero. done pulses for one cycle after the last beat transfers.
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   start              frame request, sampled only while idle
//   sata1/2/3_supported, max_lba_address   frame content, latched on start
//   o_dat/o_val/o_eop  frame stream; o_rdy from the sink
//   busy               frame in progress
//   done               one-cycle completion pulse
module sata_identify_generator
   import sata_identify_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sata1_supported,
   input  logic        sata2_supported,
   input  logic        sata3_supported,
   input  logic [47:0] max_lba_address,
   output logic [31:0] o_dat,
   output logic        o_val,
   output logic        o_eop,
   input  logic        o_rdy,
   output logic        busy,
   output logic        done
);

   gen_state_e  state_q, state_d;
   logic [7:0]  n_q, n_d;
   logic [7:0]  acc_q, acc_d;
   logic [2:0]  caps_q, caps_d;
   logic [47:0] lba_q, lba_d;
   logic        done_q, done_d;

   logic [31:0] mux_dat;
   logic        sending;

   sata_identify_dword_mux u_dword_mux (
      .beat_i (n_q),
      .caps_i (caps_q),
      .lba_i  (lba_q),
      .acc_i  (acc_q),
      .dat_o  (mux_dat)
   );

   assign sending = (state_q == StSend);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      acc_d   = acc_q;
      caps_d  = caps_q;
      lba_d   = lba_q;
      done_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StSend;
               n_d     = '0;
               acc_d   = '0;
               caps_d  = {sata3_supported, sata2_supported, sata1_supported};
               lba_d   = max_lba_address;
            end
         end
         StSend: begin
            if (o_rdy) begin
               if (n_q == BEAT_LAST) begin
                  state_d = StIdle;
                  n_d     = '0;
                  done_d  = 1'b1;
               end else begin
                  n_d = n_q + 8'd1;
                  // Header beat is not part of the identify payload.
                  if (n_q != BEAT_HEADER) begin
                     acc_d = acc_q + dword_byte_sum(mux_dat);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_val = sending;
      o_eop = sending && (n_q == BEAT_LAST);
      o_dat = sending ? mux_dat : '0;
      busy  = sending;
      done  = done_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         n_q     <= '0;
         acc_q   <= '0;
         caps_q  <= '0;
         lba_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         acc_q   <= acc_d;
         caps_q  <= caps_d;
         lba_q   <= lba_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/sata_identify_generator.md
SATA_IDENTIFY_GENERATOR -- requirements
Module: sata_identify_generator

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 reset  in  1  synchronous active-high reset.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 start  in  1  request to emit one IDENTIFY data frame; sampled only in IDLE.
REQ-005 sata1_supported, sata2_supported, sata3_supported  in  1 each  SATA generation capability flags.
REQ-006 max_lba_address  in  48  maximum user LBA.
REQ-007 o_dat  out  32  frame dword.
REQ-008 o_val  out  1  o_dat valid.
REQ-009 o_eop  out  1  last dword of frame.
REQ-010 o_rdy  in  1  sink ready; a beat transfers when o_val & o_rdy.
REQ-011 busy  out  1  frame in progress (SEND state).
REQ-012 done  out  1  one-cycle pulse, cycle after the last beat transfers.

Function
REQ-013 FSM states SHALL be IDLE and SEND; IDLE->SEND on start; SEND->IDLE when the beat with o_eop transfers.
REQ-014 On start in IDLE, all capability and LBA inputs SHALL be latched; input changes during SEND SHALL not affect the frame.
REQ-015 start asserted during SEND SHALL be ignored; it is not queued.
REQ-016 o_val SHALL rise the cycle after start is accepted (latency 1) and stay high through the whole frame.
REQ-017 Beat index n (0..128) SHALL advance only on transfer; o_dat/o_eop SHALL hold stable while o_val & ~o_rdy.
REQ-018 Frame length SHALL be 129 dwords; o_eop SHALL be high only at n=128.
REQ-019 n=0: o_dat[7:0] SHALL be DATA_FIS (0x46), o_dat[31:8]=0.
REQ-020 n=1..128 SHALL carry identify words 2(n-1) in [15:0] and 2(n-1)+1 in [31:16]; undefined words are 0.
REQ-021 Word 60/61 (n=31): 28-bit max LBA = max_lba_address if < 0x0FFFFFFF, else 0x0FFFFFFF.
REQ-022 Word 76 (n=39, bits [3:1]) SHALL be {sata3,sata2,sata1}; other bits 0.
REQ-023 Word 83 (n=42, bits [31:16]) SHALL be 0x4400 (48-bit addressing supported, word valid).
REQ-024 Words 100..103 (n=51 full dword = max_lba_address[31:0]; n=52 [15:0] = max_lba_address[47:32], [31:16]=0).
REQ-025 Word 255 (n=128): [23:16]=0xA5 signature; [31:24]=checksum, so the 8-bit sum of all 512 identify bytes (n=1..128) is 0.
REQ-026 The checksum SHALL be an 8-bit mod-256 accumulator: cleared on start, adding the four bytes of each transferred dword n=1..127.
REQ-027 Byte 511 SHALL equal (0 - acc - 0xA5) mod 256.
REQ-028 done SHALL pulse exactly once per frame; busy SHALL be 0 in the done cycle.
REQ-029 A new start SHALL be accepted in the same cycle done is high.

Reset
REQ-030 When reset is high, the block SHALL enter IDLE with n=0 and accumulator=0.
REQ-031 Under reset, o_val=0, o_eop=0, o_dat=0, busy=0 and done=0.
REQ-032 Reset mid-frame SHALL abort the frame without o_eop; no done pulse.

Structure
REQ-033 DATA_FIS SHALL come from sata_defs.svh.
REQ-034 Package sata_identify_pkg SHALL hold the constants FIS_LEN=129, the beat indices (31, 39, 42, 51, 52, 128), LBA28_MAX and the signature 0xA5; the matching parser SHALL share it.
REQ-035 The dword builder SHALL be one sub-module, sata_identify_dword_mux: combinational, beat index plus latched fields in, o_dat out.

Verification
REQ-036 Capabilities 3'b011, LBA 0x0000_1D1C_5970, o_rdy=1 -> 129 beats, no gaps; n=39 = 0x0000_0006; n=51 = 0x1D1C_5970; n=52 = 0x0000_0000; done at cycle 130 after start.
REQ-037 LBA 0x0000_0FFF_FFFF and 0x1234_5678_9ABC -> n=31 = 0x0FFF_FFFF both times; n=52 = 0x0000_1234 for the second.
REQ-038 Random o_rdy (50% duty) -> o_dat stable while stalled; byte sum of n=1..128 = 0x00; o_dat[23:16] at n=128 = 0xA5.
REQ-039 start pulsed at n=60, inputs changed mid-frame -> single frame, contents from original latch.
REQ-040 Reset at n=70 -> o_val=0 next cycle, no done; the following start yields a correct full frame with a correct checksum.
REQ-041 Back-to-back: start held high -> second frame header follows done cycle; both checksums valid.
